acc_datapath: RTL and testbench

- Datapath partner for the accumulate-N control FSM. It decodes the 5-bit opcode ACC_Ctrl issued by the controller and holds the count, address-pointer and accumulator registers.
- It returns the count-continue flag the controller branches on, and it fetches operands through a zero-latency read port.
- It presents the final sum with a valid flag once the controller enters its hold/done state.

---
 rtl/acc_datapath_if.sv | 36 +++
 rtl/acc_datapath.sv | 99 +++++++++
 tb/tb_acc_datapath.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_datapath_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : acc_datapath_if
// Purpose  : Bundles the controller-to-datapath opcode/operand signals and the
//            datapath status/result signals of the accumulate-N block.
// Ports    : master - controller side (drives acc_ctrl, n_in, rd_data)
//            slave  - datapath side (drives rd_addr, count_judge, acc_sum,
//                     sum_valid, done_pulse, illegal_op)
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface acc_datapath_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 5,
  parameter int SUM_W  = DATA_W + CNT_W
);
  logic [4:0]        acc_ctrl;
  logic [CNT_W-1:0]  n_in;
  logic [CNT_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              count_judge;
  logic [SUM_W-1:0]  acc_sum;
  logic              sum_valid;
  logic              done_pulse;
  logic              illegal_op;

  modport master (
    output acc_ctrl, n_in, rd_data,
    input  rd_addr, count_judge, acc_sum, sum_valid, done_pulse, illegal_op
  );

  modport slave (
    input  acc_ctrl, n_in, rd_data,
    output rd_addr, count_judge, acc_sum, sum_valid, done_pulse, illegal_op
  );
endinterface
`default_nettype wire

// File: rtl/acc_datapath.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : acc_datapath
// Purpose  : Datapath for the accumulate-N controller. Decodes the 5-bit
//            opcode, keeps count / address pointer / accumulator registers,
//            returns the continue flag and presents the final sum.
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - acc_datapath_if.slave (opcode, n_in, read port, status)
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module acc_datapath #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 5,
  parameter int SUM_W  = DATA_W + CNT_W
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  acc_datapath_if.slave bus
);

  localparam logic [4:0] c_OP_CLEAR = 5'b00000;
  localparam logic [4:0] c_OP_LOAD  = 5'b10111;
  localparam logic [4:0] c_OP_ADD   = 5'b01111;
  localparam logic [4:0] c_OP_STEP  = 5'b10100;
  localparam logic [4:0] c_OP_HOLD  = 5'b11111;

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_ptr;
  logic [SUM_W-1:0] r_acc;
  logic             r_sum_valid;
  logic             r_illegal;
  logic             r_hold_d;

  logic             w_is_step;
  logic             w_is_hold;
  logic             w_cnt_nz;

  assign w_is_step = (bus.acc_ctrl == c_OP_STEP);
  assign w_is_hold = (bus.acc_ctrl == c_OP_HOLD);
  assign w_cnt_nz  = (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_ptr       <= '0;
      r_acc       <= '0;
      r_sum_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_hold_d    <= 1'b0;
    end else begin
      // sum_valid is only ever set by HOLD, so any other opcode drops it
      r_sum_valid <= w_is_hold;
      r_hold_d    <= w_is_hold;
      case (bus.acc_ctrl)
        c_OP_CLEAR: begin
          r_count   <= '0;
          r_ptr     <= '0;
          r_acc     <= '0;
          r_illegal <= 1'b0;
        end
        c_OP_LOAD: begin
          r_count <= bus.n_in;
          r_ptr   <= '0;
          r_acc   <= '0;
        end
        c_OP_ADD: begin
          // count==0 suppresses the add so that N=0 yields a zero sum
          if (w_cnt_nz) begin
            r_acc <= r_acc + SUM_W'(bus.rd_data);
          end
        end
        c_OP_STEP: begin
          if (w_cnt_nz) begin
            r_count <= r_count - CNT_W'(1);
            r_ptr   <= r_ptr + CNT_W'(1);
          end
        end
        c_OP_HOLD: begin
          // all state frozen
        end
        default: begin
          r_illegal <= 1'b1;
        end
      endcase
    end
  end

  // During STEP the decrement is still pending, so "another ADD needed"
  // means the pre-decrement count is above one.
  assign bus.count_judge = w_is_step ? (r_count > CNT_W'(1)) : w_cnt_nz;
  assign bus.rd_addr     = r_ptr;
  assign bus.acc_sum     = r_acc;
  assign bus.sum_valid   = r_sum_valid;
  assign bus.done_pulse  = w_is_hold & ~r_hold_d;
  assign bus.illegal_op  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_acc_datapath.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_acc_datapath
// Purpose  : Directed self-checking bench for acc_datapath.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_acc_datapath;

  localparam logic [4:0] OP_CLEAR = 5'b00000;
  localparam logic [4:0] OP_LOAD  = 5'b10111;
  localparam logic [4:0] OP_ADD   = 5'b01111;
  localparam logic [4:0] OP_STEP  = 5'b10100;
  localparam logic [4:0] OP_HOLD  = 5'b11111;
  localparam logic [4:0] OP_BAD   = 5'b00101;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] mem [32];

  always #5 clk = ~clk;

  acc_datapath_if #(.DATA_W(8), .CNT_W(5), .SUM_W(13)) bus ();

  acc_datapath #(.DATA_W(8), .CNT_W(5), .SUM_W(13)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // zero-latency operand memory
  always_comb bus.rd_data = mem[bus.rd_addr];

  // Apply an opcode at the falling edge; outputs are sampled 1 ns later,
  // well before the next rising edge.
  task automatic drive(input logic [4:0] op);
    @(negedge clk);
    bus.acc_ctrl = op;
    #1;
  endtask

  task automatic fill_inc();
    for (int a = 0; a < 32; a++) mem[a] = 8'(a + 1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.acc_ctrl = OP_CLEAR;
    bus.n_in = '0;
    fill_inc();
    #12;
    total++;
    if (bus.acc_sum !== 13'd0 || bus.sum_valid !== 1'b0 || bus.illegal_op !== 1'b0 ||
        bus.rd_addr !== 5'd0) begin
      bad++;
      $display("FAIL reset_state: acc=%0d sv=%b ill=%b addr=%0d required 0/0/0/0",
               bus.acc_sum, bus.sum_valid, bus.illegal_op, bus.rd_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(OP_CLEAR);
    drive(OP_CLEAR);
    total++;
    if (bus.acc_sum !== 13'd0 || bus.count_judge !== 1'b0 || bus.done_pulse !== 1'b0 ||
        bus.sum_valid !== 1'b0) begin
      bad++;
      $display("FAIL clear_state: acc=%0d judge=%b done=%b sv=%b required all 0",
               bus.acc_sum, bus.count_judge, bus.done_pulse, bus.sum_valid);
    end
  endtask

  task automatic test_sum4();
    logic exp_j [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    fill_inc();
    bus.n_in = 5'd4;
    drive(OP_LOAD);
    for (int i = 0; i < 4; i++) begin
      drive(OP_ADD);
      total++;
      if (bus.rd_addr !== 5'(i) || bus.count_judge !== 1'b1) begin
        bad++;
        $display("FAIL sum4_add%0d: addr=%0d judge=%b required %0d/1",
                 i, bus.rd_addr, bus.count_judge, i);
      end
      drive(OP_STEP);
      total++;
      if (bus.count_judge !== exp_j[i]) begin
        bad++;
        $display("FAIL sum4_step%0d_judge: got %b required %b", i, bus.count_judge, exp_j[i]);
      end
    end
    for (int h = 0; h < 4; h++) begin
      drive(OP_HOLD);
      total++;
      if (bus.acc_sum !== 13'd10 || bus.done_pulse !== (h == 0) ||
          (h > 0 && bus.sum_valid !== 1'b1)) begin
        bad++;
        $display("FAIL sum4_hold%0d: acc=%0d done=%b sv=%b required 10/%b/%b",
                 h, bus.acc_sum, bus.done_pulse, bus.sum_valid, (h == 0), (h > 0));
      end
    end
    drive(OP_CLEAR);
    drive(OP_CLEAR);
    total++;
    if (bus.sum_valid !== 1'b0 || bus.acc_sum !== 13'd0) begin
      bad++;
      $display("FAIL sum4_leave_hold: sv=%b acc=%0d required 0/0", bus.sum_valid, bus.acc_sum);
    end
  endtask

  task automatic test_n_zero();
    for (int a = 0; a < 32; a++) mem[a] = 8'hFF;
    bus.n_in = 5'd0;
    drive(OP_LOAD);
    drive(OP_ADD);
    total++;
    if (bus.count_judge !== 1'b0) begin
      bad++;
      $display("FAIL nzero_add_judge: got %b required 0", bus.count_judge);
    end
    drive(OP_STEP);
    total++;
    if (bus.count_judge !== 1'b0 || bus.acc_sum !== 13'd0) begin
      bad++;
      $display("FAIL nzero_step: judge=%b acc=%0d required 0/0", bus.count_judge, bus.acc_sum);
    end
    drive(OP_HOLD);
    total++;
    if (bus.acc_sum !== 13'd0 || bus.rd_addr !== 5'd0 || bus.count_judge !== 1'b0) begin
      bad++;
      $display("FAIL nzero_hold: acc=%0d addr=%0d judge=%b required 0/0/0",
               bus.acc_sum, bus.rd_addr, bus.count_judge);
    end
  endtask

  task automatic test_max_n();
    int addr_err = 0;
    int judge_err = 0;
    for (int a = 0; a < 32; a++) mem[a] = 8'hFF;
    bus.n_in = 5'd31;
    drive(OP_LOAD);
    for (int i = 0; i < 31; i++) begin
      drive(OP_ADD);
      if (bus.rd_addr !== 5'(i)) addr_err++;
      drive(OP_STEP);
      if (bus.count_judge !== (i < 30)) judge_err++;
    end
    total++;
    if (addr_err != 0 || judge_err != 0) begin
      bad++;
      $display("FAIL maxn_walk: addr errors=%0d judge errors=%0d required 0/0", addr_err, judge_err);
    end
    drive(OP_HOLD);
    total++;
    if (bus.acc_sum !== 13'h1EE1 || bus.rd_addr !== 5'd31 || bus.done_pulse !== 1'b1) begin
      bad++;
      $display("FAIL maxn_result: acc=%0d addr=%0d done=%b required 7905/31/1",
               bus.acc_sum, bus.rd_addr, bus.done_pulse);
    end
  endtask

  task automatic test_illegal();
    fill_inc();
    bus.n_in = 5'd5;
    drive(OP_LOAD);
    drive(OP_ADD);
    drive(OP_STEP);
    drive(OP_ADD);
    drive(OP_BAD);
    total++;
    if (bus.illegal_op !== 1'b0 || bus.acc_sum !== 13'd3) begin
      bad++;
      $display("FAIL illegal_before: ill=%b acc=%0d required 0/3", bus.illegal_op, bus.acc_sum);
    end
    drive(OP_STEP);
    total++;
    if (bus.illegal_op !== 1'b1 || bus.acc_sum !== 13'd3 || bus.rd_addr !== 5'd1 ||
        bus.count_judge !== 1'b1) begin
      bad++;
      $display("FAIL illegal_hold: ill=%b acc=%0d addr=%0d judge=%b required 1/3/1/1",
               bus.illegal_op, bus.acc_sum, bus.rd_addr, bus.count_judge);
    end
    drive(OP_ADD);
    drive(OP_CLEAR);
    total++;
    if (bus.illegal_op !== 1'b1 || bus.acc_sum !== 13'd6) begin
      bad++;
      $display("FAIL illegal_sticky: ill=%b acc=%0d required 1/6", bus.illegal_op, bus.acc_sum);
    end
    drive(OP_CLEAR);
    total++;
    if (bus.illegal_op !== 1'b0 || bus.acc_sum !== 13'd0) begin
      bad++;
      $display("FAIL illegal_clear: ill=%b acc=%0d required 0/0", bus.illegal_op, bus.acc_sum);
    end
  endtask

  task automatic test_reset_mid_run();
    fill_inc();
    bus.n_in = 5'd5;
    drive(OP_LOAD);
    drive(OP_ADD);
    drive(OP_STEP);
    drive(OP_ADD);
    drive(OP_STEP);
    drive(OP_ADD);
    total++;
    if (bus.acc_sum !== 13'd3) begin
      bad++;
      $display("FAIL rstmid_pre: acc=%0d required 3", bus.acc_sum);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.acc_sum !== 13'd0 || bus.sum_valid !== 1'b0 || bus.rd_addr !== 5'd0) begin
      bad++;
      $display("FAIL rstmid_async: acc=%0d sv=%b addr=%0d required 0/0/0",
               bus.acc_sum, bus.sum_valid, bus.rd_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.n_in = 5'd2;
    drive(OP_LOAD);
    for (int i = 0; i < 2; i++) begin
      drive(OP_ADD);
      drive(OP_STEP);
    end
    drive(OP_HOLD);
    drive(OP_HOLD);
    total++;
    if (bus.acc_sum !== 13'd3 || bus.sum_valid !== 1'b1 || bus.done_pulse !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_rerun: acc=%0d sv=%b done=%b required 3/1/0",
               bus.acc_sum, bus.sum_valid, bus.done_pulse);
    end
  endtask

  initial begin
    test_reset();
    test_sum4();
    test_n_zero();
    test_max_n();
    test_illegal();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
